// File: rtl/fc_pkg.sv
// Fast-command scheduler shared definitions: 4-bit command codes,
// their 8-bit line bytes and the code-to-byte encoder.
package fc_pkg;

    localparam logic [3:0] CMD_IDLE     = 4'd0;
    localparam logic [3:0] CMD_LINK_RST = 4'd1;
    localparam logic [3:0] CMD_BCR      = 4'd2;
    localparam logic [3:0] CMD_STP      = 4'd3;
    localparam logic [3:0] CMD_L1ACR    = 4'd4;
    localparam logic [3:0] CMD_CHG_INJ  = 4'd5;
    localparam logic [3:0] CMD_L1A      = 4'd6;
    localparam logic [3:0] CMD_L1A_BCR  = 4'd7;
    localparam logic [3:0] CMD_WS_START = 4'd8;
    localparam logic [3:0] CMD_WS_STOP  = 4'd9;

    localparam logic [7:0] BYTE_IDLE     = 8'hF0;
    localparam logic [7:0] BYTE_LINK_RST = 8'h33;
    localparam logic [7:0] BYTE_BCR      = 8'h5A;
    localparam logic [7:0] BYTE_STP      = 8'h55;
    localparam logic [7:0] BYTE_L1ACR    = 8'h66;
    localparam logic [7:0] BYTE_CHG_INJ  = 8'h69;
    localparam logic [7:0] BYTE_L1A      = 8'h96;
    localparam logic [7:0] BYTE_L1A_BCR  = 8'h99;
    localparam logic [7:0] BYTE_WS_START = 8'hA5;
    localparam logic [7:0] BYTE_WS_STOP  = 8'hAA;

    // Unassigned codes go out as IDLE so a bad register value is harmless.
    function automatic logic [7:0] fc_encode(input logic [3:0] code);
        logic [7:0] b;
        case (code)
            CMD_LINK_RST: b = BYTE_LINK_RST;
            CMD_BCR:      b = BYTE_BCR;
            CMD_STP:      b = BYTE_STP;
            CMD_L1ACR:    b = BYTE_L1ACR;
            CMD_CHG_INJ:  b = BYTE_CHG_INJ;
            CMD_L1A:      b = BYTE_L1A;
            CMD_L1A_BCR:  b = BYTE_L1A_BCR;
            CMD_WS_START: b = BYTE_WS_START;
            CMD_WS_STOP:  b = BYTE_WS_STOP;
            default:      b = BYTE_IDLE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/fc_scheduler_timer.sv
// Per-slot timer: offset/period counter, armed and pending flags.
// Ports: start_ev/stop_ev events, slot config, grant in; req/drop/armed out.
module fc_slot_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk40,
    input  logic             rstn,
    input  logic             start_ev,
    input  logic             stop_ev,
    input  logic             en,
    input  logic             periodic,
    input  logic [CNT_W-1:0] offset,
    input  logic [CNT_W-1:0] period,
    input  logic             grant,
    output logic             req,
    output logic             drop,
    output logic             armed
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             armed_q, armed_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fire;

    always_comb begin
        fire  = armed_q && (cnt_q == '0);
        req   = pending_q | fire;
        drop  = pending_q & fire & ~grant;
        armed = armed_q;

        armed_d = armed_q;
        cnt_d   = cnt_q;
        // pending is a 0/1 token count: old + fire - grant, clipped at 1
        pending_d = pending_q ? (fire | ~grant) : (fire & ~grant);

        // Reloads are value-1 because the zero-count cycle is itself
        // the firing cycle; zero is treated as one.
        if (fire) begin
            if (periodic)
                cnt_d = (period == '0) ? '0 : period - ONE;
            else
                armed_d = 1'b0;
        end else if (armed_q) begin
            cnt_d = cnt_q - ONE;
        end

        if (stop_ev) begin
            armed_d   = 1'b0;
            pending_d = 1'b0;
        end else if (start_ev && en) begin
            armed_d   = 1'b1;
            cnt_d     = (offset == '0) ? '0 : offset - ONE;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk40) begin
        if (!rstn) begin
            armed_q   <= 1'b0;
            pending_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            armed_q   <= armed_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/fc_scheduler.sv
// Fast-command scheduler: N_SLOT timed command slots plus external L1A,
// arbitrated and encoded into one registered byte per clk40.
// Ports: start/stop/err_inj levels, slot config buses, ext_trig, err_mask;
// outputs fc_byte, armed, drop_cnt.
module fc_scheduler
    import fc_pkg::*;
#(
    parameter int N_SLOT = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk40,
    input  logic                    rstn,
    input  logic                    start_pulse,
    input  logic                    stop_pulse,
    input  logic [N_SLOT-1:0]       slot_en,
    input  logic [N_SLOT-1:0]       slot_periodic,
    input  logic [4*N_SLOT-1:0]     slot_cmd,
    input  logic [CNT_W*N_SLOT-1:0] slot_offset,
    input  logic [CNT_W*N_SLOT-1:0] slot_period,
    input  logic                    ext_trig,
    input  logic                    err_inj_pulse,
    input  logic [7:0]              err_mask,
    output logic [7:0]              fc_byte,
    output logic [N_SLOT-1:0]       armed,
    output logic [7:0]              drop_cnt
);

    logic [2:0]        st_q, st_d;
    logic [2:0]        sp_q, sp_d;
    logic [2:0]        ei_q, ei_d;
    logic              start_ev, stop_ev, err_ev;
    logic [N_SLOT-1:0] req, drop, gnt;
    logic [3:0]        code;
    logic [7:0]        fc_byte_q, fc_byte_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic [8:0]        drop_sum;

    always_comb begin
        st_d     = {st_q[1:0], start_pulse};
        sp_d     = {sp_q[1:0], stop_pulse};
        ei_d     = {ei_q[1:0], err_inj_pulse};
        stop_ev  = sp_q[1] & ~sp_q[2];
        start_ev = st_q[1] & ~st_q[2] & ~stop_ev;
        err_ev   = ei_q[1] & ~ei_q[2];
    end

    for (genvar i = 0; i < N_SLOT; i++) begin : g_slot
        fc_slot_timer #(.CNT_W(CNT_W)) u_timer (
            .clk40    (clk40),
            .rstn     (rstn),
            .start_ev (start_ev),
            .stop_ev  (stop_ev),
            .en       (slot_en[i]),
            .periodic (slot_periodic[i]),
            .offset   (slot_offset[CNT_W*i +: CNT_W]),
            .period   (slot_period[CNT_W*i +: CNT_W]),
            .grant    (gnt[i]),
            .req      (req[i]),
            .drop     (drop[i]),
            .armed    (armed[i])
        );
    end

    // ext_trig beats every slot; among slots the lowest index wins.
    always_comb begin
        gnt  = '0;
        code = CMD_IDLE;
        if (ext_trig) begin
            code = CMD_L1A;
        end else begin
            for (int i = N_SLOT - 1; i >= 0; i--) begin
                if (req[i]) begin
                    gnt    = '0;
                    gnt[i] = 1'b1;
                    code   = slot_cmd[4*i +: 4];
                end
            end
        end
        fc_byte_d = fc_encode(code) ^ (err_ev ? err_mask : 8'h00);
    end

    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int i = 0; i < N_SLOT; i++)
            drop_sum = drop_sum + {8'd0, drop[i]};
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk40) begin
        if (!rstn) begin
            st_q       <= '0;
            sp_q       <= '0;
            ei_q       <= '0;
            fc_byte_q  <= BYTE_IDLE;
            drop_cnt_q <= '0;
        end else begin
            st_q       <= st_d;
            sp_q       <= sp_d;
            ei_q       <= ei_d;
            fc_byte_q  <= fc_byte_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign fc_byte  = fc_byte_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_fc_scheduler.sv
// Self-checking bench for fc_scheduler: encoder table per command code,
// then directed multi-cycle sequences for timing and corner cases.
`timescale 1ns/1ps
module tb_fc_scheduler;

    localparam int NS = 4;
    localparam int CW = 16;

    logic            clk40 = 1'b0;
    logic            rstn;
    logic            start_pulse, stop_pulse;
    logic [NS-1:0]   slot_en, slot_periodic;
    logic [4*NS-1:0] slot_cmd;
    logic [CW*NS-1:0] slot_offset, slot_period;
    logic            ext_trig, err_inj_pulse;
    logic [7:0]      err_mask;
    logic [7:0]      fc_byte;
    logic [NS-1:0]   armed;
    logic [7:0]      drop_cnt;

    int total = 0;
    int bad   = 0;

    fc_scheduler #(.N_SLOT(NS), .CNT_W(CW)) dut (
        .clk40         (clk40),
        .rstn          (rstn),
        .start_pulse   (start_pulse),
        .stop_pulse    (stop_pulse),
        .slot_en       (slot_en),
        .slot_periodic (slot_periodic),
        .slot_cmd      (slot_cmd),
        .slot_offset   (slot_offset),
        .slot_period   (slot_period),
        .ext_trig      (ext_trig),
        .err_inj_pulse (err_inj_pulse),
        .err_mask      (err_mask),
        .fc_byte       (fc_byte),
        .armed         (armed),
        .drop_cnt      (drop_cnt)
    );

    always #12 clk40 = ~clk40;

    typedef struct {
        logic [3:0] code;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg(input int s, input logic en, input logic per,
                       input logic [3:0] cmd, input logic [CW-1:0] off,
                       input logic [CW-1:0] prd);
        slot_en[s]            = en;
        slot_periodic[s]      = per;
        slot_cmd[4*s +: 4]    = cmd;
        slot_offset[CW*s +: CW] = off;
        slot_period[CW*s +: CW] = prd;
    endtask

    // start rises at the current negedge and drops one cycle later;
    // returns having consumed one negedge
    task automatic pulse_start();
        start_pulse = 1'b1;
        @(negedge clk40);
        start_pulse = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk40);
    endtask

    initial begin
        vecs[0]  = '{4'd0,  8'hF0};
        vecs[1]  = '{4'd1,  8'h33};
        vecs[2]  = '{4'd2,  8'h5A};
        vecs[3]  = '{4'd3,  8'h55};
        vecs[4]  = '{4'd4,  8'h66};
        vecs[5]  = '{4'd5,  8'h69};
        vecs[6]  = '{4'd6,  8'h96};
        vecs[7]  = '{4'd7,  8'h99};
        vecs[8]  = '{4'd8,  8'hA5};
        vecs[9]  = '{4'd9,  8'hAA};
        vecs[10] = '{4'd10, 8'hF0};
        vecs[11] = '{4'd11, 8'hF0};
        vecs[12] = '{4'd12, 8'hF0};
        vecs[13] = '{4'd13, 8'hF0};
        vecs[14] = '{4'd14, 8'hF0};
        vecs[15] = '{4'd15, 8'hF0};

        rstn = 1'b0;
        start_pulse = 0; stop_pulse = 0; ext_trig = 0;
        err_inj_pulse = 0; err_mask = 8'h00;
        slot_en = '0; slot_periodic = '0; slot_cmd = '0;
        slot_offset = '0; slot_period = '0;
        idle(3);
        chk("reset_byte", fc_byte, 8'hF0);
        chk("reset_armed", armed, 0);
        chk("reset_drop", drop_cnt, 0);
        rstn = 1'b1;
        idle(4);

        // one-shot offset 0: byte visible 4 negedges after start rises
        for (int k = 0; k < 16; k++) begin
            cfg(0, 1'b1, 1'b0, vecs[k].code, 16'd0, 16'd0);
            pulse_start();
            idle(2);
            chk($sformatf("armed_c%0d", k), armed[0], 1'b1);
            idle(1);
            chk($sformatf("enc_c%0d", k), fc_byte, vecs[k].exp_byte);
            chk($sformatf("oneshot_c%0d", k), armed[0], 1'b0);
            idle(1);
            chk($sformatf("after_c%0d", k), fc_byte, 8'hF0);
            idle(2);
        end
        cfg(0, 1'b0, 1'b0, 4'd0, 16'd0, 16'd0);

        // two one-shots at offset 10: slot1 wins, slot2 deferred one cycle
        cfg(1, 1'b1, 1'b0, 4'd5, 16'd10, 16'd0);
        cfg(2, 1'b1, 1'b0, 4'd6, 16'd10, 16'd0);
        pulse_start();
        idle(11);
        chk("off10_pre", fc_byte, 8'hF0);
        idle(1);
        chk("off10_chg", fc_byte, 8'h69);
        idle(1);
        chk("off10_l1a", fc_byte, 8'h96);
        idle(1);
        chk("off10_post", fc_byte, 8'hF0);
        chk("off10_drop", drop_cnt, 0);
        chk("off10_armed", armed, 0);
        cfg(1, 1'b0, 1'b0, 4'd0, 16'd0, 16'd0);
        cfg(2, 1'b0, 1'b0, 4'd0, 16'd0, 16'd0);
        idle(3);

        // BCR periodic 3564, offset 0
        cfg(0, 1'b1, 1'b1, 4'd2, 16'd0, 16'd3564);
        pulse_start();
        idle(3);
        chk("bcr_first", fc_byte, 8'h5A);
        for (int r = 0; r < 2; r++) begin
            int n;
            n = 0;
            do begin
                @(negedge clk40);
                n++;
            end while (fc_byte !== 8'h5A && n < 4000);
            chk($sformatf("bcr_gap%0d", r), n, 3564);
        end
        stop_pulse = 1'b1;
        idle(3);
        stop_pulse = 1'b0;
        chk("stop_armed", armed, 0);
        idle(3);

        // period 1 with ext_trig for 5 cycles
        cfg(0, 1'b1, 1'b1, 4'd2, 16'd0, 16'd1);
        pulse_start();
        idle(5);
        chk("p1_run", fc_byte, 8'h5A);
        ext_trig = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk40);
            chk($sformatf("ext_l1a%0d", j), fc_byte, 8'h96);
        end
        ext_trig = 1'b0;
        @(negedge clk40);
        chk("ext_resume", fc_byte, 8'h5A);
        chk("ext_drop", drop_cnt, 4);
        @(negedge clk40);
        chk("ext_resume2", fc_byte, 8'h5A);
        chk("ext_drop2", drop_cnt, 4);

        // synchronous reset mid-run
        rstn = 1'b0;
        @(negedge clk40);
        chk("mrst_byte", fc_byte, 8'hF0);
        chk("mrst_armed", armed, 0);
        chk("mrst_drop", drop_cnt, 0);
        rstn = 1'b1;
        @(negedge clk40);
        chk("mrst_after", fc_byte, 8'hF0);
        cfg(0, 1'b0, 1'b0, 4'd0, 16'd0, 16'd0);
        idle(3);

        // error injection during idle
        err_mask = 8'h01;
        err_inj_pulse = 1'b1;
        idle(2);
        chk("err_before", fc_byte, 8'hF0);
        idle(1);
        chk("err_hit", fc_byte, 8'hF1);
        idle(1);
        chk("err_after", fc_byte, 8'hF0);
        err_inj_pulse = 1'b0;
        idle(3);
        chk("err_fall", fc_byte, 8'hF0);

        // start and stop together: stop wins
        cfg(0, 1'b1, 1'b1, 4'd2, 16'd0, 16'd1);
        start_pulse = 1'b1;
        stop_pulse  = 1'b1;
        idle(3);
        chk("ss_armed", armed, 0);
        idle(1);
        chk("ss_byte", fc_byte, 8'hF0);
        start_pulse = 1'b0;
        stop_pulse  = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fc_scheduler.md
FC_SCHEDULER -- requirements
Module: fc_scheduler

Interface
REQ-001 Parameter N_SLOT, default 4, number of independent command slots (1..8).
REQ-002 Parameter CNT_W, default 16, width of per-slot offset/period counters.
REQ-003 clk40  in  1  40 MHz system clock; all logic on rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 start_pulse  in  1  level from control register; rising edge arms all enabled slots.
REQ-006 stop_pulse  in  1  level; rising edge disarms all slots.
REQ-007 slot_en  in  N_SLOT  per-slot enable, sampled at start event.
REQ-008 slot_periodic  in  N_SLOT  1 = periodic, 0 = one-shot.
REQ-009 slot_cmd  in  4*N_SLOT  per-slot 4-bit command code, slot i at bits [4i+3:4i].
REQ-010 slot_offset  in  CNT_W*N_SLOT  cycles from start event to first fire.
REQ-011 slot_period  in  CNT_W*N_SLOT  cycles between fires in periodic mode.
REQ-012 ext_trig  in  1  single-cycle external L1A request, highest priority.
REQ-013 err_inj_pulse  in  1  level; rising edge corrupts one output byte.
REQ-014 err_mask  in  8  XOR mask applied on error injection.
REQ-015 fc_byte  out  8  encoded fast-command byte, one per clk40, MSB first to downstream serializer.
REQ-016 armed  out  N_SLOT  per-slot armed status.
REQ-017 drop_cnt  out  8  saturating count of lost fires.

Function
REQ-018 Edges of start_pulse, stop_pulse and err_inj_pulse SHALL be detected through a 3-flop chain; event = stage2 & ~stage3, one cycle wide.
REQ-019 On start event, each slot with slot_en=1 SHALL set armed, load its counter with slot_offset, and clear its pending flag.
REQ-020 Armed slot: counter==0 -> fire; else decrement by 1 per cycle.
REQ-021 On fire, periodic slot SHALL reload slot_period-1; one-shot slot SHALL clear armed.
REQ-022 Periodic slot with slot_period==0 SHALL be treated as period 1 (fire every cycle).
REQ-023 Fire sets pending; a fire while pending already set SHALL increment drop_cnt (saturating at 255) and keep one pending.
REQ-024 Arbitration per cycle: ext_trig first (code L1A), then lowest-index pending slot; winner's pending clears in the grant cycle.
REQ-025 ext_trig while a slot is pending SHALL defer that slot; ext_trig is never dropped.
REQ-026 No grant -> code IDLE.
REQ-027 Encoding: 0 IDLE F0, 1 LinkReset 33, 2 BCR 5A, 3 STP 55, 4 L1ACR 66, 5 ChargeInj 69, 6 L1A 96, 7 L1A_BCR 99, 8 WS_start A5, 9 WS_stop AA; codes 10-15 SHALL encode as F0.
REQ-028 fc_byte SHALL be registered: grant in cycle t appears on fc_byte in cycle t+1.
REQ-029 Error-injection event in cycle t SHALL XOR err_mask into the byte emitted in t+1, exactly one byte.
REQ-030 Stop event SHALL clear all armed and pending flags; the byte already granted still emits.
REQ-031 Start and stop events in same cycle: stop wins.
REQ-032 Start event while armed SHALL re-arm (restart from offset), discarding pending.
REQ-033 Slot inputs other than slot_en are live; changes take effect at next counter reload.

Reset
REQ-034 In reset: fc_byte=F0, armed=0, pending=0, counters=0, drop_cnt=0, edge chains=0.
REQ-035 Reset mid-operation SHALL take effect next edge with no partial command emitted afterwards.

Structure
REQ-036 Package fc_pkg SHALL hold the 4-bit code constants, the 8-bit byte constants and the encode function.
REQ-037 Sub-module fc_slot_timer (one per slot, generate loop) SHALL hold counter, armed and pending logic; arbiter, encoder and error injection stay in top.

Verification
REQ-038 N_SLOT=4, slot0 BCR periodic period 3564 offset 0: BCR bytes 5A exactly every 3564 cycles, first one 2 cycles after start event.
REQ-039 slot1 ChargeInj offset 10 one-shot, slot2 L1A offset 10 one-shot: 69 at t+11, 96 at t+12, drop_cnt=0.
REQ-040 slot0 periodic period 1 plus ext_trig every cycle for 5 cycles: five 96 bytes, slot0 drop_cnt=4, then 5A resumes.
REQ-041 err_mask=0x01 injection during idle: single byte F1, neighbours F0.
REQ-042 slot_cmd=4'hC armed: fires emit F0; stop and start in same cycle: armed stays 0.
REQ-043 rstn low for one cycle mid-run: next fc_byte F0, armed=0, drop_cnt=0.
